// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Op codes and FSM state encoding shared by alu_seq and its
//               multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_ADC = 3'b111;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_MUL  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq
// Description : Unsigned shift-add multiplier, one partial product per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);
    import alu_pkg::*;

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic               w_last;

    always_comb begin
        w_addend = r_mplier[0] ? r_mcand : '0;
        w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
        w_last   = (r_cnt == CW'(WIDTH));
    end

    // The carry out of the upper-half add is shifted back in as the new MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (w_last) begin
                r_busy <= 1'b0;
            end else begin
                r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

    assign done = r_busy & w_last;
    assign prod = r_acc;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Registered ALU with valid/ready input, persistent carry flag
//               and a multi-cycle multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic             c,
    output logic             v,
    output logic             n,
    output logic             z
);
    import alu_pkg::*;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_y;
    logic               r_c, r_v, r_n, r_z, r_out_valid;

    logic               w_accept;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_bop;
    logic               w_cin;
    logic [WIDTH:0]     w_sum;
    logic               w_load;
    logic [WIDTH-1:0]   w_y_nxt;
    logic               w_c_nxt, w_v_nxt, w_n_nxt;

    assign in_ready = rst_n & (r_state == ST_IDLE);
    assign w_accept = in_valid & in_ready;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_mul_start),
        .a     (a),
        .b     (b),
        .done  (w_mul_done),
        .prod  (w_prod)
    );

    // ADC reads the registered carry, so a preceding ADD/SUB forwards naturally.
    always_comb begin
        w_bop = (op == OP_SUB) ? ~b : b;
        w_cin = (op == OP_SUB) ? 1'b1 : ((op == OP_ADC) ? r_c : 1'b0);
        w_sum = {1'b0, a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mul_start = 1'b0;
        w_load      = 1'b0;
        w_y_nxt     = r_y;
        w_c_nxt     = r_c;
        w_v_nxt     = r_v;
        w_n_nxt     = r_n;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (op == OP_MUL) begin
                        w_mul_start = 1'b1;
                        w_state_nxt = ST_MUL;
                    end else begin
                        w_load  = 1'b1;
                        w_c_nxt = 1'b0;
                        w_v_nxt = 1'b0;
                        w_n_nxt = 1'b0;
                        case (op)
                            OP_ADD, OP_SUB, OP_ADC: begin
                                w_y_nxt = w_sum[WIDTH-1:0];
                                w_c_nxt = w_sum[WIDTH];
                                w_v_nxt = (a[WIDTH-1] == w_bop[WIDTH-1]) &&
                                          (w_sum[WIDTH-1] != a[WIDTH-1]);
                                w_n_nxt = w_sum[WIDTH-1];
                            end
                            OP_AND:  w_y_nxt = a & b;
                            OP_OR:   w_y_nxt = a | b;
                            OP_XOR:  w_y_nxt = a ^ b;
                            default: w_y_nxt = ~a;
                        endcase
                    end
                end
            end
            ST_MUL: begin
                if (w_mul_done) begin
                    w_load      = 1'b1;
                    w_y_nxt     = w_prod[WIDTH-1:0];
                    w_c_nxt     = |w_prod[2*WIDTH-1:WIDTH];
                    w_v_nxt     = |w_prod[2*WIDTH-1:WIDTH];
                    w_n_nxt     = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y         <= '0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_n         <= 1'b0;
            r_z         <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_load;
            if (w_load) begin
                r_y <= w_y_nxt;
                r_c <= w_c_nxt;
                r_v <= w_v_nxt;
                r_n <= w_n_nxt;
                r_z <= (w_y_nxt == '0);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign c         = r_c;
    assign v         = r_v;
    assign n         = r_n;
    assign z         = r_z;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq at WIDTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic        out_valid;
    logic [15:0] y;
    logic        c, v, n, z;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .y         (y),
        .c         (c),
        .v         (v),
        .n         (n),
        .z         (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one op for exactly one accept edge; returns #1 after that edge.
    task automatic issue(input logic [2:0] o, input logic [15:0] aa, input logic [15:0] bb);
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        a  = aa;
        b  = bb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b1;
        op = 3'b000;
        a = 16'h1234;
        b = 16'h1111;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: got %b want 0", in_ready);
        end
        total++;
        if ({out_valid, y, c, v, n, z} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outs: got ov=%b y=%h cvnz=%b%b%b%b want all 0", out_valid, y, c, v, n, z);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add;
        issue(3'b000, 16'h7FFF, 16'h0001);
        total++;
        if ({out_valid, y, c, v, n, z} !== {1'b1, 16'h8000, 4'b0110}) begin
            bad++;
            $display("FAIL add_ovf: got ov=%b y=%h cvnz=%b%b%b%b want ov=1 y=8000 cvnz=0110", out_valid, y, c, v, n, z);
        end
        @(posedge clk);
        #1;
        total++;
        if ({out_valid, y, c, v, n, z} !== {1'b0, 16'h8000, 4'b0110}) begin
            bad++;
            $display("FAIL add_hold: got ov=%b y=%h cvnz=%b%b%b%b want ov=0 y=8000 cvnz=0110", out_valid, y, c, v, n, z);
        end
    endtask

    task automatic test_sub;
        issue(3'b001, 16'h0005, 16'h0005);
        total++;
        if ({out_valid, y, c, v, n, z} !== {1'b1, 16'h0000, 4'b1001}) begin
            bad++;
            $display("FAIL sub_zero: got ov=%b y=%h cvnz=%b%b%b%b want ov=1 y=0000 cvnz=1001", out_valid, y, c, v, n, z);
        end
        issue(3'b001, 16'h0000, 16'h0001);
        total++;
        if ({out_valid, y, c, v, n, z} !== {1'b1, 16'hFFFF, 4'b0010}) begin
            bad++;
            $display("FAIL sub_borrow: got ov=%b y=%h cvnz=%b%b%b%b want ov=1 y=ffff cvnz=0010", out_valid, y, c, v, n, z);
        end
    endtask

    task automatic test_logic;
        issue(3'b010, 16'hF0F0, 16'hFF00);
        total++;
        if ({y, c, v, n, z} !== {16'hF000, 4'b0000}) begin
            bad++;
            $display("FAIL and: got y=%h cvnz=%b%b%b%b want y=f000 cvnz=0000", y, c, v, n, z);
        end
        issue(3'b011, 16'h1200, 16'h0034);
        total++;
        if ({y, c, v, n, z} !== {16'h1234, 4'b0000}) begin
            bad++;
            $display("FAIL or: got y=%h cvnz=%b%b%b%b want y=1234 cvnz=0000", y, c, v, n, z);
        end
        issue(3'b100, 16'hAAAA, 16'hAAAA);
        total++;
        if ({y, c, v, n, z} !== {16'h0000, 4'b0001}) begin
            bad++;
            $display("FAIL xor: got y=%h cvnz=%b%b%b%b want y=0000 cvnz=0001", y, c, v, n, z);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        in_valid = 1'b1;
        op = 3'b000;
        a = 16'hFFFF;
        b = 16'h0001;
        @(negedge clk);
        op = 3'b111;
        a = 16'h0001;
        b = 16'h0001;
        total++;
        if ({out_valid, y, c, v, n, z} !== {1'b1, 16'h0000, 4'b1001}) begin
            bad++;
            $display("FAIL b2b_add: got ov=%b y=%h cvnz=%b%b%b%b want ov=1 y=0000 cvnz=1001", out_valid, y, c, v, n, z);
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if ({out_valid, y, c, v, n, z} !== {1'b1, 16'h0003, 4'b0000}) begin
            bad++;
            $display("FAIL b2b_adc: got ov=%b y=%h cvnz=%b%b%b%b want ov=1 y=0003 cvnz=0000", out_valid, y, c, v, n, z);
        end
    endtask

    task automatic test_mul;
        int early;
        int busy_ok;
        early = 0;
        busy_ok = 1;
        @(negedge clk);
        in_valid = 1'b1;
        op = 3'b110;
        a = 16'h0100;
        b = 16'h0100;
        @(posedge clk);
        #1;
        // Keep a competing ADD asserted while the multiplier is busy.
        op = 3'b000;
        a = 16'h0001;
        b = 16'h0001;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) early++;
            if (in_ready) busy_ok = 0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (early != 0 || busy_ok != 1) begin
            bad++;
            $display("FAIL mul_busy: got early_valid=%0d ready_low=%0d want 0 and 1", early, busy_ok);
        end
        @(posedge clk);
        #1;
        total++;
        if ({out_valid, in_ready, y, c, v, n, z} !== {1'b1, 1'b1, 16'h0000, 4'b1101}) begin
            bad++;
            $display("FAIL mul_big: got ov=%b rdy=%b y=%h cvnz=%b%b%b%b want ov=1 rdy=1 y=0000 cvnz=1101", out_valid, in_ready, y, c, v, n, z);
        end
        @(posedge clk);
        #1;
        total++;
        if ({out_valid, y} !== {1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL mul_no_accept: got ov=%b y=%h want ov=0 y=0000", out_valid, y);
        end
        issue(3'b110, 16'h0003, 16'h0005);
        repeat (17) @(posedge clk);
        #1;
        total++;
        if ({out_valid, y, c, v, n, z} !== {1'b1, 16'h000F, 4'b0000}) begin
            bad++;
            $display("FAIL mul_small: got ov=%b y=%h cvnz=%b%b%b%b want ov=1 y=000f cvnz=0000", out_valid, y, c, v, n, z);
        end
    endtask

    task automatic test_not;
        issue(3'b000, 16'hFFFF, 16'h0001);
        total++;
        if (c !== 1'b1) begin
            bad++;
            $display("FAIL not_setup_carry: got c=%b want 1", c);
        end
        issue(3'b101, 16'h00FF, 16'h0000);
        total++;
        if ({out_valid, y, c, v, n, z} !== {1'b1, 16'hFF00, 4'b0000}) begin
            bad++;
            $display("FAIL not: got ov=%b y=%h cvnz=%b%b%b%b want ov=1 y=ff00 cvnz=0000", out_valid, y, c, v, n, z);
        end
    endtask

    task automatic test_reset_mid_mul;
        int stray;
        stray = 0;
        issue(3'b110, 16'h0003, 16'h0005);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({out_valid, in_ready, y, c, v, n, z} !== 22'd0) begin
            bad++;
            $display("FAIL mid_mul_reset: got ov=%b rdy=%b y=%h cvnz=%b%b%b%b want all 0", out_valid, in_ready, y, c, v, n, z);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_mul_ready: got %b want 1", in_ready);
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL mid_mul_abort: got %0d stray out_valid want 0", stray);
        end
        issue(3'b000, 16'h0002, 16'h0003);
        total++;
        if ({out_valid, y, c, v, n, z} !== {1'b1, 16'h0005, 4'b0000}) begin
            bad++;
            $display("FAIL post_reset_add: got ov=%b y=%h cvnz=%b%b%b%b want ov=1 y=0005 cvnz=0000", out_valid, y, c, v, n, z);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        op = '0;
        test_reset;
        test_add;
        test_sub;
        test_logic;
        test_back_to_back;
        test_mul;
        test_not;
        test_reset_mid_mul;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 16-bit combinational ALU.
- WIDTH-bit datapath with a valid/ready input handshake, registered result and flags, and a persistent carry flag used by an add-with-carry op.
- Adds a multi-cycle unsigned shift-add multiplier.
- Sits between the register-file read stage and write-back in the datapath.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- CW, $clog2(WIDTH)+1, multiplier cycle-counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  operation code.
- out_valid  out  1  one-cycle pulse; y and flags are new.
- y  out  WIDTH  result (registered).
- c  out  1  carry flag (registered, persistent).
- v  out  1  overflow flag.
- n  out  1  negative flag.
- z  out  1  zero flag.

Behaviour:
- Reset: synchronous, sampled on the rising clk edge while rst_n=0.
  - y=0, c=v=n=z=0, out_valid=0, state=IDLE, multiplier counter=0.
  - in_ready=0 while rst_n=0.
- Accept: in_valid & in_ready at edge t. a, b and op are captured; inputs at other times are ignored.
- Op codes:
  - 000 ADD: y=a+b.
  - 001 SUB: y=a+~b+1.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT: y=~a.
  - 110 MUL: y=low WIDTH bits of unsigned a*b.
  - 111 ADC: y=a+b+c, where c is the stored flag at accept time.
- Flags for ADD/SUB/ADC:
  - c = carry-out of bit WIDTH-1. For SUB, c=1 means no borrow.
  - v = signed overflow: operand sign bits (b inverted for SUB) equal and differ from y[WIDTH-1].
  - n = y[WIDTH-1].
- Flags for logic ops: c=v=n=0.
- Flags for MUL: c=v=1 if the upper WIDTH product bits are nonzero, else 0; n=0.
- z = (y==0) for every op.
- Latency:
  - Single-cycle ops (all except MUL): out_valid=1 at edge t+1. in_ready stays 1, giving back-to-back throughput of 1/cycle.
  - An ADC accepted the cycle after an ADD/SUB uses the carry produced by that op; flags forward through the registered c.
- MUL state machine, states IDLE and MUL:
  - IDLE -> MUL on accept of op=110. Load multiplicand and multiplier, clear the 2*WIDTH accumulator, counter=0. in_ready=0 while in MUL.
  - In MUL, each cycle: if the multiplier LSB=1, add the multiplicand to the upper accumulator half; then shift right; counter++.
  - When the counter reaches WIDTH: y and flags are written, out_valid pulses, and the state returns to IDLE.
  - Result appears at edge t+WIDTH+1 after the accept edge t. in_ready returns to 1 in the same cycle out_valid is high.
- Flag hold: y and flags hold their values between out_valid pulses. c persists indefinitely, so it is only changed by a completing op.
- No output backpressure: the consumer must take y on the out_valid cycle.
- Reset mid-MUL: abort immediately with no out_valid, and every register takes its reset value.
- in_valid=1 while in_ready=0: no effect; the source holds its data (standard valid/ready).
- All arithmetic is modulo 2^WIDTH; there are no X or undefined outputs for any op value.

Decomposition:
- Shared package alu_pkg:
  - op-code localparams: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MUL, OP_ADC.
  - state encoding: ST_IDLE, ST_MUL.
- One sub-module alu_mul_seq, the shift-add multiplier:
  - inputs: start, a, b.
  - outputs: done, prod[2*WIDTH-1:0].
- Single-cycle datapath, flag logic and handshake stay in alu_seq.

Test Plan (WIDTH=16):
- Apply reset, then ADD 0x7FFF+0x0001 -> next-cycle out_valid; y=0x8000, c=0, v=1, n=1, z=0.
- SUB 0x0005-0x0005 -> y=0x0000, c=1, v=0, n=0, z=1. SUB 0x0000-0x0001 -> y=0xFFFF, c=0, n=1.
- Back-to-back ADD 0xFFFF+0x0001, then ADC 0x0001+0x0001 on consecutive cycles:
  - first result y=0x0000, c=1, z=1;
  - second result y=0x0003, c=0.
  - out_valid is high two consecutive cycles.
- MUL 0x0100*0x0100 -> in_ready=0 for 16 cycles, out_valid at accept+17; y=0x0000, c=v=1, z=1. A concurrent in_valid is not accepted.
  - MUL 0x0003*0x0005 -> y=0x000F, c=v=0.
- NOT 0x00FF -> y=0xFF00, c=v=n=0, z=0; the prior c=1 is cleared.
- rst_n=0 for one edge mid-MUL (cycle 5) -> no out_valid; y=0, flags=0. After release, in_ready=1 and a new ADD completes normally.
